pipeline_subtractor: RTL and testbench



---
 rtl/pipeline_subtractor.sv | 119 +++++++++++
 tb/tb_pipeline_subtractor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_subtractor.sv
// Four-stage 32-bit pipelined subtractor d = a - b - bi, one 8-bit borrow slice per stage.
// Unconsumed operand bytes ride skew registers; finished low bytes travel forward so all bits exit together.
module pipeline_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bi,
  output logic [31:0] d,
  output logic        bo,
  output logic        zero,
  output logic        ov,
  output logic        out_valid
);

  // Returns {borrow_out, diff}: a + ~b + ~borrow_in, borrow_out = ~carry.
  function automatic logic [8:0] sub_slice(input logic [7:0] x, input logic [7:0] y,
                                           input logic bin);
    logic [8:0] t;
    t = {1'b0, x} + {1'b0, ~y} + {8'd0, ~bin};
    return {~t[8], t[7:0]};
  endfunction

  // Stage 1: slice 0
  logic        s1_vld_q, s1_bor_q, s1_z_q;
  logic [7:0]  s1_res_q;
  logic [31:8] s1_a_q, s1_b_q;
  logic [8:0]  s1_d;

  // Stage 2: slice 1
  logic        s2_vld_q, s2_bor_q, s2_z_q;
  logic [15:0] s2_res_q;
  logic [31:16] s2_a_q, s2_b_q;
  logic [8:0]  s2_d;

  // Stage 3: slice 2
  logic        s3_vld_q, s3_bor_q, s3_z_q;
  logic [23:0] s3_res_q;
  logic [31:24] s3_a_q, s3_b_q;
  logic [8:0]  s3_d;

  // Stage 4: slice 3 and flags (these are the output registers)
  logic        vld_q, bo_q, zero_q, ov_q;
  logic [31:0] d_q;
  logic [8:0]  s4_d;
  logic        ov_d;

  always_comb begin
    s1_d = sub_slice(a[7:0], b[7:0], bi);
    s2_d = sub_slice(s1_a_q[15:8], s1_b_q[15:8], s1_bor_q);
    s3_d = sub_slice(s2_a_q[23:16], s2_b_q[23:16], s2_bor_q);
    s4_d = sub_slice(s3_a_q[31:24], s3_b_q[31:24], s3_bor_q);
    ov_d = (s3_a_q[31] ^ s3_b_q[31]) & (s4_d[7] ^ s3_a_q[31]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_bor_q <= 1'b0;
      s1_z_q   <= 1'b0;
      s1_res_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_bor_q <= 1'b0;
      s2_z_q   <= 1'b0;
      s2_res_q <= '0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s3_vld_q <= 1'b0;
      s3_bor_q <= 1'b0;
      s3_z_q   <= 1'b0;
      s3_res_q <= '0;
      s3_a_q   <= '0;
      s3_b_q   <= '0;
      vld_q    <= 1'b0;
      bo_q     <= 1'b0;
      zero_q   <= 1'b0;
      ov_q     <= 1'b0;
      d_q      <= '0;
    end else if (en) begin
      s1_vld_q <= in_valid;
      s1_bor_q <= s1_d[8];
      s1_z_q   <= (s1_d[7:0] == 8'd0);
      s1_res_q <= s1_d[7:0];
      s1_a_q   <= a[31:8];
      s1_b_q   <= b[31:8];

      s2_vld_q <= s1_vld_q;
      s2_bor_q <= s2_d[8];
      s2_z_q   <= s1_z_q & (s2_d[7:0] == 8'd0);
      s2_res_q <= {s2_d[7:0], s1_res_q};
      s2_a_q   <= s1_a_q[31:16];
      s2_b_q   <= s1_b_q[31:16];

      s3_vld_q <= s2_vld_q;
      s3_bor_q <= s3_d[8];
      s3_z_q   <= s2_z_q & (s3_d[7:0] == 8'd0);
      s3_res_q <= {s3_d[7:0], s2_res_q};
      s3_a_q   <= s2_a_q[31:24];
      s3_b_q   <= s2_b_q[31:24];

      vld_q    <= s3_vld_q;
      bo_q     <= s4_d[8];
      zero_q   <= s3_z_q & (s4_d[7:0] == 8'd0);
      ov_q     <= ov_d;
      d_q      <= {s4_d[7:0], s3_res_q};
    end
  end

  assign d         = d_q;
  assign bo        = bo_q;
  assign zero      = zero_q;
  assign ov        = ov_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_pipeline_subtractor.sv
// Directed bench for pipeline_subtractor: hand-computed vectors plus a 33-bit reference for the stream.
module tb_pipeline_subtractor;
  logic        clk = 1'b0;
  logic        rst, en, in_valid, bi;
  logic [31:0] a, b, d;
  logic        bo, zero, ov, out_valid;

  int checks = 0;
  int errors = 0;

  // Expected-result delay line (4 enabled edges) and the value currently offered
  logic        mv[4];
  logic [31:0] md[4];
  logic        mbo[4], mz[4], mov[4];
  logic        nv, nbo, nz, nov;
  logic [31:0] nd;

  logic [31:0] sa[8];
  logic [31:0] sb[8];
  logic        sbi[8];

  pipeline_subtractor dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .bi(bi),
    .d(d), .bo(bo), .zero(zero), .ov(ov), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; md[i] = '0; mbo[i] = 1'b0; mz[i] = 1'b0; mov[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vbi,
                       input logic vv, input logic [31:0] ed, input logic ebo,
                       input logic ez, input logic eov);
    a = va; b = vb; bi = vbi; in_valid = vv;
    nv = vv; nd = ed; nbo = ebo; nz = ez; nov = eov;
  endtask

  task automatic drive_ref(input logic [31:0] va, input logic [31:0] vb, input logic vbi);
    logic [32:0] r;
    r = {1'b0, va} - {1'b0, vb} - {32'd0, vbi};
    drive(va, vb, vbi, 1'b1, r[31:0], r[32], (r[31:0] == 32'd0),
          (va[31] ^ vb[31]) & (r[31] ^ va[31]));
  endtask

  task automatic idle();
    drive(32'hdeadbeef, 32'h0badf00d, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (rst) begin
      clear_model();
    end else if (en) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1]; md[i] = md[i-1]; mbo[i] = mbo[i-1]; mz[i] = mz[i-1]; mov[i] = mov[i-1];
      end
      mv[0] = nv; md[0] = nd; mbo[0] = nbo; mz[0] = nz; mov[0] = nov;
    end
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mv[3]});
    if (mv[3]) begin
      chk({tag, ".d"},    d,               md[3]);
      chk({tag, ".bo"},   {31'd0, bo},     {31'd0, mbo[3]});
      chk({tag, ".zero"}, {31'd0, zero},   {31'd0, mz[3]});
      chk({tag, ".ov"},   {31'd0, ov},     {31'd0, mov[3]});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".d"},         d,                   32'd0);
    chk({tag, ".bo"},        {31'd0, bo},         32'd0);
    chk({tag, ".zero"},      {31'd0, zero},       32'd0);
    chk({tag, ".ov"},        {31'd0, ov},         32'd0);
    chk({tag, ".out_valid"}, {31'd0, out_valid},  32'd0);
  endtask

  initial begin
    sa[0] = 32'h00000005; sb[0] = 32'h00000003; sbi[0] = 1'b0;
    sa[1] = 32'h00000003; sb[1] = 32'h00000005; sbi[1] = 1'b1;
    sa[2] = 32'hffffffff; sb[2] = 32'hffffffff; sbi[2] = 1'b1;
    sa[3] = 32'h7fffffff; sb[3] = 32'hffffffff; sbi[3] = 1'b0;
    sa[4] = 32'h01000000; sb[4] = 32'h00000001; sbi[4] = 1'b0;
    sa[5] = 32'hcafe1234; sb[5] = 32'h1234cafe; sbi[5] = 1'b1;
    sa[6] = 32'h00ff00ff; sb[6] = 32'h00ff0100; sbi[6] = 1'b0;
    sa[7] = 32'h89abcdef; sb[7] = 32'h76543210; sbi[7] = 1'b0;

    clear_model();
    rst = 1'b1; en = 1'b1;
    idle();
    #1;
    chk_reset_outputs("reset_init");
    tick("reset_hold");
    tick("reset_hold");
    rst = 1'b0;

    // Hand-computed directed vectors, issued back to back
    drive(32'h30561c86, 32'h00002475, 1'b0, 1'b1, 32'h3055f811, 1'b0, 1'b0, 1'b0);
    tick("basic");
    drive(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hffffffff, 1'b1, 1'b0, 1'b0);
    tick("underflow");
    drive(32'h12345678, 32'h12345678, 1'b1, 1'b1, 32'hffffffff, 1'b1, 1'b0, 1'b0);
    tick("ripple");
    drive(32'ha0987557, 32'ha0987557, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
    tick("zero");
    drive(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7fffffff, 1'b0, 1'b0, 1'b1);
    tick("overflow");
    idle();
    for (int i = 0; i < 5; i++) tick("drain1");

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive_ref(sa[i], sb[i], sbi[i]);
      tick("preload");
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_async");
    clear_model();
    tick("reset_mid");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick("no_stale");
    drive(32'h30561c86, 32'h00002475, 1'b0, 1'b1, 32'h3055f811, 1'b0, 1'b0, 1'b0);
    tick("post_reset");
    idle();
    for (int i = 0; i < 4; i++) tick("post_reset_drain");

    // Streaming, then stall with a full pipe
    for (int i = 0; i < 8; i++) begin
      drive_ref(sa[i], sb[i], sbi[i]);
      tick("stream");
    end
    en = 1'b0;
    drive_ref(32'h11111111, 32'h22222222, 1'b0);
    for (int i = 0; i < 3; i++) tick("stall");
    idle();
    en = 1'b1;
    for (int i = 0; i < 6; i++) tick("release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
